// File: rtl/uart_hex_sender.sv
// Formats one 64-bit capture as an ASCII hex line ("xxxxxxxx yyyyyyyy\r\n" or
// "xxxxxxxx\r\n") and pushes it into a UART TX FIFO, one character per accepted write.
module uart_hex_sender (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    input  logic        abort,
    input  logic        tx_full,
    output logic [7:0]  tx_wdata,
    output logic        tx_wen,
    output logic        flushing_wq,
    output logic        snd_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_SP   = 3'd2,
        S_W1   = 3'd3,
        S_CR   = 3'd4,
        S_LF   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  nib, nib_nxt;
    logic [63:0] shadow;
    logic        mode;
    logic        accept;
    logic [31:0] w0_sh, w1_sh;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10)
            return 8'h30 + {4'h0, v};
        else
            return 8'h57 + {4'h0, v};
    endfunction

    // Nibble nib counts from the most significant end: shift by (7-nib)*4.
    assign w0_sh  = shadow[31:0]  >> {~nib, 2'b00};
    assign w1_sh  = shadow[63:32] >> {~nib, 2'b00};
    assign accept = (state == S_IDLE) && rdata_snd_start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            nib    <= 3'd0;
            shadow <= 64'd0;
            mode   <= 1'b0;
        end else begin
            state <= state_nxt;
            nib   <= nib_nxt;
            if (accept) begin
                shadow <= rdata_snd;
                mode   <= pc_print_sel;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        nib_nxt     = nib;
        tx_wen      = 1'b0;
        tx_wdata    = 8'h00;
        flushing_wq = 1'b0;
        snd_busy    = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_W0;
                    nib_nxt   = 3'd0;
                end
            end
            S_W0: begin
                tx_wdata = hex_ascii(w0_sh[3:0]);
                tx_wen   = !tx_full;
                if (tx_wen) begin
                    if (nib == 3'd7) begin
                        nib_nxt   = 3'd0;
                        state_nxt = mode ? S_CR : S_SP;
                    end else begin
                        nib_nxt = nib + 3'd1;
                    end
                end
            end
            S_SP: begin
                tx_wdata = 8'h20;
                tx_wen   = !tx_full;
                if (tx_wen) begin
                    nib_nxt   = 3'd0;
                    state_nxt = S_W1;
                end
            end
            S_W1: begin
                tx_wdata = hex_ascii(w1_sh[3:0]);
                tx_wen   = !tx_full;
                if (tx_wen) begin
                    if (nib == 3'd7) begin
                        nib_nxt   = 3'd0;
                        state_nxt = S_CR;
                    end else begin
                        nib_nxt = nib + 3'd1;
                    end
                end
            end
            S_CR: begin
                tx_wdata = 8'h0D;
                tx_wen   = !tx_full;
                if (tx_wen)
                    state_nxt = S_LF;
            end
            S_LF: begin
                tx_wdata = 8'h0A;
                tx_wen   = !tx_full;
                if (tx_wen)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                flushing_wq = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                nib_nxt   = 3'd0;
            end
        endcase

        // Cancel wins over everything else: drop the line without a flush pulse.
        if (abort && (state != S_IDLE)) begin
            state_nxt   = S_IDLE;
            nib_nxt     = 3'd0;
            flushing_wq = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Scoreboard bench for uart_hex_sender: expected characters come from a string-level
// model of each line; a negedge monitor pops and compares every TX write and flush.
module tb_uart_hex_sender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdata_snd_start = 1'b0;
    logic [63:0] rdata_snd = 64'd0;
    logic        pc_print_sel = 1'b0;
    logic        abort = 1'b0;
    logic        tx_full = 1'b0;
    logic [7:0]  tx_wdata;
    logic        tx_wen;
    logic        flushing_wq;
    logic        snd_busy;

    uart_hex_sender dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdata_snd_start (rdata_snd_start),
        .rdata_snd       (rdata_snd),
        .pc_print_sel    (pc_print_sel),
        .abort           (abort),
        .tx_full         (tx_full),
        .tx_wdata        (tx_wdata),
        .tx_wen          (tx_wen),
        .flushing_wq     (flushing_wq),
        .snd_busy        (snd_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int exp_flush = 0;
    int flush_total = 0;
    int last_flush_cyc = 0;
    int first_wen_cyc = 0;
    bit wen_armed = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic string line_str(input logic [63:0] d, input logic sel);
        if (sel)
            return $sformatf("%08h\r\n", d[31:0]);
        else
            return $sformatf("%08h %08h\r\n", d[31:0], d[63:32]);
    endfunction

    // Monitor: every write and every flush pulse is checked against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_wen) begin
            if (wen_armed) begin
                first_wen_cyc = cyc;
                wen_armed = 0;
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: actual=%0h required=none", tx_wdata);
            end else begin
                e = exp_q.pop_front();
                if (tx_wdata !== e) begin
                    failures++;
                    $display("FAIL tx_char: actual=%0h required=%0h", tx_wdata, e);
                end
            end
        end
        if (flushing_wq) begin
            checks++;
            if (exp_flush == 0) begin
                failures++;
                $display("FAIL unexpected_flush: actual=1 required=0 at cyc %0d", cyc);
            end else if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL early_flush: actual=%0d chars pending required=0", exp_q.size());
            end else begin
                exp_flush--;
            end
            flush_total++;
            last_flush_cyc = cyc;
        end
    end

    task automatic start_line(input logic [63:0] d, input logic sel, input bit expect_accept);
        string s;
        @(posedge clk); #1;
        rdata_snd = d;
        pc_print_sel = sel;
        rdata_snd_start = 1'b1;
        if (expect_accept) begin
            s = line_str(d, sel);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            exp_flush++;
            wen_armed = 1;
        end
        @(negedge clk);
        if (expect_accept) start_cyc = cyc;
        @(posedge clk); #1;
        rdata_snd_start = 1'b0;
        rdata_snd = $urandom();
    endtask

    task automatic wait_flush(input string name);
        int n;
        bit seen;
        n = flush_total;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (flush_total > n) seen = 1;
        end
        if (!seen) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout: actual=no_flush required=flush", name);
        end
    endtask

    initial begin
        int ftot;
        logic [63:0] d;
        logic sel;

        #1;
        check("reset_tx_wen", tx_wen, 0);
        check("reset_tx_wdata", tx_wdata, 8'h00);
        check("reset_flush", flushing_wq, 0);
        check("reset_busy", snd_busy, 0);
        #20 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Dump line, no stalls
        start_line(64'h89ABCDEF_01234567, 1'b0, 1);
        wait_flush("dump");
        check("dump_first_wen_lat", first_wen_cyc - start_cyc, 1);
        check("dump_flush_lat", last_flush_cyc - start_cyc, 20);
        @(negedge clk);
        check("dump_busy_after", snd_busy, 0);

        // PC line, upper word must be ignored
        start_line({32'hDEAD_BEEF, 32'h0000_1F40}, 1'b1, 1);
        wait_flush("pc");
        check("pc_first_wen_lat", first_wen_cyc - start_cyc, 1);
        check("pc_flush_lat", last_flush_cyc - start_cyc, 11);

        // Backpressure: stall 5 cycles after the 3rd write
        start_line(64'h89ABCDEF_01234567, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1 tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wen", tx_wen, 0);
            check("stall_wdata", tx_wdata, 8'h33);
        end
        @(posedge clk); #1 tx_full = 1'b0;
        wait_flush("stall");
        check("stall_flush_lat", last_flush_cyc - start_cyc, 25);

        // Second start during W1 is dropped
        ftot = flush_total;
        start_line(64'h0F1E2D3C_4B5A6978, 1'b0, 1);
        repeat (10) @(posedge clk);
        start_line(64'h11111111_22222222, 1'b1, 0);
        wait_flush("restart");
        repeat (30) @(negedge clk);
        check("restart_one_flush", flush_total - ftot, 1);

        // Abort during the 6th character
        ftot = flush_total;
        start_line(64'hCAFEF00D_A5A55A5A, 1'b0, 1);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        exp_flush = 0;
        @(negedge clk);
        check("abort_busy", snd_busy, 0);
        check("abort_wen", tx_wen, 0);
        repeat (30) @(negedge clk);
        check("abort_no_flush", flush_total - ftot, 0);
        start_line(64'h76543210_FEDCBA98, 1'b0, 1);
        wait_flush("after_abort");
        check("after_abort_lat", last_flush_cyc - start_cyc, 20);

        // Asynchronous reset mid-W0
        ftot = flush_total;
        start_line(64'h13579BDF_2468ACE0, 1'b0, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_wen", tx_wen, 0);
        check("async_rst_wdata", tx_wdata, 8'h00);
        check("async_rst_flush", flushing_wq, 0);
        check("async_rst_busy", snd_busy, 0);
        exp_q.delete();
        exp_flush = 0;
        #13 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_no_flush", flush_total - ftot, 0);
        start_line(64'h0000FFFF_ABCD0123, 1'b1, 1);
        wait_flush("after_rst");
        check("after_rst_lat", last_flush_cyc - start_cyc, 11);

        // Randomized lines with random backpressure and ignored extra starts
        for (int n = 0; n < 25; n++) begin
            bit seen;
            int f0;
            d = {$urandom(), $urandom()};
            sel = $urandom_range(0, 1);
            start_line(d, sel, 1);
            f0 = flush_total;
            seen = 0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(posedge clk); #1;
                tx_full = ($urandom_range(0, 9) < 3);
                rdata_snd_start = ($urandom_range(0, 19) == 0);
                rdata_snd = {$urandom(), $urandom()};
                pc_print_sel = $urandom_range(0, 1);
                @(negedge clk);
                if (flush_total > f0) seen = 1;
            end
            rdata_snd_start = 1'b0;
            tx_full = 1'b0;
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL random_timeout: actual=no_flush required=flush line %0d", n);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_flush_pending", exp_flush, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_hex_sender.md
UART_HEX_SENDER -- requirements
Module: uart_hex_sender

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL clear on rst_n low without waiting for a clk edge.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rdata_snd_start  input  1  single-cycle request to format and send one line.
REQ-005 rdata_snd  input  64  payload; [31:0] = first word (data_0 / PC value), [63:32] = second word (data_1).
REQ-006 pc_print_sel  input  1  sampled with the start pulse; 1 = single-word line, 0 = two-word dump line.
REQ-007 abort  input  1  synchronous cancel of the line in progress (read_stop | pgm_stop).
REQ-008 tx_full  input  1  UART TX FIFO full; no write while high.
REQ-009 tx_wdata  output  8  ASCII character to the TX FIFO.
REQ-010 tx_wen  output  1  TX FIFO write strobe; one character per high cycle.
REQ-011 flushing_wq  output  1  one-cycle pulse when the line is fully enqueued.
REQ-012 snd_busy  output  1  high from the cycle after an accepted start until flushing_wq or abort.

Function
REQ-013 On rdata_snd_start in IDLE: latch rdata_snd into a 64-bit shadow register and pc_print_sel into a mode flag; go to W0.
REQ-014 rdata_snd_start while not IDLE SHALL be ignored, with no effect on the shadow, mode or line in progress.
REQ-015 States: IDLE, W0, SP, W1, CR, LF, DONE; 3-bit nibble counter nib.
REQ-016 W0: emit word0 nibbles MSB first ([31:28] down to [3:0]); nib increments per accepted write; after nib=7: to SP if mode=0, else to CR.
REQ-017 SP: emit 8'h20; then W1 with nib=0.
REQ-018 W1: emit word1 nibbles MSB first ([63:60] down to [35:32]); after nib=7: to CR.
REQ-019 CR emits 8'h0D, then LF emits 8'h0A, then DONE.
REQ-020 DONE: flushing_wq=1 for exactly one cycle, tx_wen=0; next state IDLE.
REQ-021 Hex encoding: 0-9 -> 8'h30-8'h39; a-f lowercase -> 8'h61-8'h66.
REQ-022 tx_wen = state in {W0,SP,W1,CR,LF} & ~tx_full; state and nib SHALL advance only when tx_wen=1.
REQ-023 While tx_full=1, tx_wdata SHALL hold its current character and state and nib SHALL hold.
REQ-024 Latency: start at cycle N with tx_full=0 -> first tx_wen at N+1; with no stalls, flushing_wq at N+20 (dump, 19 chars) or N+11 (PC, 10 chars).
REQ-025 abort in any non-IDLE state -> IDLE next cycle, no further writes, no flushing_wq; abort has priority over tx_full and over start.
REQ-026 Character count per line: dump mode SHALL be exactly 19 characters, PC mode exactly 10.
REQ-027 tx_wdata SHALL be 8'h00 in IDLE and DONE.

Reset
REQ-028 On reset: state=IDLE, nib=0, shadow=0, mode=0, tx_wen=0, tx_wdata=8'h00, flushing_wq=0, snd_busy=0.
REQ-029 Reset asserted mid-line SHALL abandon the line with no flushing_wq after release; the first start after release SHALL be accepted normally.

Verification
REQ-030 Dump: start, sel=0, rdata_snd=64'h89ABCDEF_01234567, tx_full=0 -> "01234567 89abcdef\r\n" (19 writes), flushing_wq at cycle 20.
REQ-031 PC: start, sel=1, rdata_snd[31:0]=32'h0000_1F40 -> "00001f40\r\n", flushing_wq at cycle 11; rdata_snd[63:32] ignored.
REQ-032 Backpressure: tx_full held high for 5 cycles after the 3rd write -> tx_wen=0 and tx_wdata stable throughout; output string unchanged; flushing_wq delayed by exactly 5 cycles.
REQ-033 Second start pulse during W1 with different data -> first line completes unchanged; the second start is dropped (only one flushing_wq).
REQ-034 abort during the 6th character -> no further tx_wen, flushing_wq never pulses, snd_busy low next cycle; a new start then produces a full line.
REQ-035 rst_n pulled low mid-W0 -> all outputs reach their reset values immediately (asynchronously); after release, no flushing_wq until a new start.
